// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM states and the
// canonical no-op instruction used to fill a flushed IF/ID register.
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    // addi x0, x0, 0
    localparam logic [31:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with load, hold and flush controls.
module if_id_reg
    import fetch_pkg::*;
#(
    parameter int unsigned PC_W = 9
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic            flush,
    input  logic [PC_W-1:0] pc_in,
    input  logic [31:0]     instr_in,
    output logic [PC_W-1:0] pc,
    output logic [31:0]     instr,
    output logic            valid
);

    logic [PC_W-1:0] pc_q;
    logic [31:0]     instr_q;
    logic            valid_q;

    // Flush wins over load so a redirect can never let a stale fetch through.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            pc_q    <= '0;
            instr_q <= NOP;
            valid_q <= 1'b0;
        end else if (load) begin
            pc_q    <= pc_in;
            instr_q <= instr_in;
            valid_q <= 1'b1;
        end
    end

    assign pc    = pc_q;
    assign instr = instr_q;
    assign valid = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC sequencing, branch redirect with target checking,
// stall hold and a sticky fault that parks the unit until reset.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned     PC_W     = 9,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            PcSel,
    input  logic [31:0]     BrPC,
    input  logic            Stall,
    input  logic [31:0]     Instr_rdata,
    output logic [PC_W-1:0] Pc,
    output logic [PC_W-1:0] IfId_PC,
    output logic [31:0]     IfId_Instr,
    output logic            IfId_Valid,
    output logic            Fault,
    output logic [31:0]     FaultPC,
    output logic [31:0]     FetchCnt
);

    fetch_state_t    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            fault_q, fault_d;
    logic [31:0]     fault_pc_q, fault_pc_d;
    logic [31:0]     cnt_q, cnt_d;
    logic            ifid_load, ifid_flush;
    logic            bad_target;

    // Target must be word aligned and fit in the PC address space.
    assign bad_target = (BrPC[1:0] != 2'b00) || ((BrPC >> PC_W) != 32'd0);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        fault_d    = fault_q;
        fault_pc_d = fault_pc_q;
        cnt_d      = cnt_q;
        ifid_load  = 1'b0;
        ifid_flush = 1'b0;
        unique case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                if (PcSel) begin
                    ifid_flush = 1'b1;
                    if (bad_target) begin
                        state_d    = HALT;
                        fault_d    = 1'b1;
                        fault_pc_d = BrPC;
                    end else begin
                        pc_d = BrPC[PC_W-1:0];
                    end
                end else if (!Stall) begin
                    ifid_load = 1'b1;
                    pc_d      = pc_q + PC_W'(4);
                    cnt_d     = cnt_q + 32'd1;
                end
            end
            HALT: ;
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            fault_q    <= 1'b0;
            fault_pc_q <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            fault_q    <= fault_d;
            fault_pc_q <= fault_pc_d;
            cnt_q      <= cnt_d;
        end
    end

    if_id_reg #(
        .PC_W (PC_W)
    ) u_if_id_reg (
        .clk      (clk),
        .reset    (reset),
        .load     (ifid_load),
        .flush    (ifid_flush),
        .pc_in    (pc_q),
        .instr_in (Instr_rdata),
        .pc       (IfId_PC),
        .instr    (IfId_Instr),
        .valid    (IfId_Valid)
    );

    assign Pc       = pc_q;
    assign Fault    = fault_q;
    assign FaultPC  = fault_pc_q;
    assign FetchCnt = cnt_q;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter PC_W, default 9, PC width in bits.
REQ-002 SHALL have parameter RESET_PC, default 0, PC value loaded on reset.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port PcSel  input  1  branch taken, from branch unit.
REQ-006 SHALL have port BrPC  input  32  branch target, from branch unit.
REQ-007 SHALL have port Stall  input  1  hazard hold request.
REQ-008 SHALL have port Instr_rdata  input  32  instruction memory data; combinational read at Pc.
REQ-009 SHALL have port Pc  output  PC_W  current fetch address to instruction memory.
REQ-010 SHALL have port IfId_PC  output  PC_W  IF/ID registered PC.
REQ-011 SHALL have port IfId_Instr  output  32  IF/ID registered instruction.
REQ-012 SHALL have port IfId_Valid  output  1  IF/ID holds a real instruction.
REQ-013 SHALL have port Fault  output  1  sticky bad-target flag.
REQ-014 SHALL have port FaultPC  output  32  captured offending BrPC.
REQ-015 SHALL have port FetchCnt  output  32  count of valid IF/ID loads.

Function
REQ-016 SHALL implement FSM states BOOT, RUN, HALT.
REQ-017 SHALL, in BOOT, hold Pc, keep IfId_Valid=0, ignore PcSel/Stall, and go to RUN after exactly one cycle.
REQ-018 SHALL apply RUN priority: PcSel > Stall > normal advance.
REQ-019 SHALL, on normal advance: IfId_PC<=Pc, IfId_Instr<=Instr_rdata, IfId_Valid<=1, Pc<=Pc+4, FetchCnt<=FetchCnt+1; one-edge latency.
REQ-020 SHALL compute Pc+4 modulo 2^PC_W (0x1FC -> 0x000 for PC_W=9).
REQ-021 SHALL, on Stall alone: hold Pc, IfId_* and FetchCnt unchanged.
REQ-022 SHALL, on valid redirect (PcSel=1, BrPC[1:0]=0, BrPC[31:PC_W]=0): Pc<=BrPC[PC_W-1:0], IfId_Valid<=0, IfId_Instr<=NOP 0x00000013, IfId_PC<=0, FetchCnt unchanged; Stall ignored that cycle.
REQ-023 SHALL, on bad redirect (PcSel=1 and BrPC[1:0]!=0 or BrPC[31:PC_W]!=0): go HALT, Fault<=1, FaultPC<=BrPC, Pc held, IfId flushed as REQ-022.
REQ-024 SHALL, in HALT: hold Pc, keep IfId_Valid=0 and IfId_Instr=NOP, hold Fault/FaultPC, ignore PcSel/Stall; exit only via reset.
REQ-025 SHALL let FetchCnt wrap modulo 2^32.

Reset
REQ-026 SHALL, on reset=1 at an edge, set: state=BOOT, Pc=RESET_PC, IfId_PC=0, IfId_Instr=0x00000013, IfId_Valid=0, Fault=0, FaultPC=0, FetchCnt=0.
REQ-027 SHALL let reset override every other input in any state, including mid-redirect and HALT.

Structure
REQ-028 SHALL place the state enum and NOP constant 0x00000013 in shared package fetch_pkg.
REQ-029 SHALL implement the IF/ID register, with load/hold/flush controls, as sub-module if_id_reg.

Verification
REQ-030 SHALL cover boot: reset 2 cycles, release, Instr_rdata=0x00500093 at Pc=0 -> after 2 edges IfId_PC=0, IfId_Instr=0x00500093, IfId_Valid=1, Pc=4, FetchCnt=1.
REQ-031 SHALL cover stall: RUN, Pc=8, Stall=1 for 3 cycles -> Pc=8, IfId_* and FetchCnt unchanged throughout.
REQ-032 SHALL cover redirect: Pc=0x10, PcSel=1, BrPC=0x40, Stall=1 -> next edge Pc=0x40, IfId_Valid=0, IfId_Instr=0x13; following edge IfId_PC=0x40, IfId_Valid=1.
REQ-033 SHALL cover faults: PcSel=1, BrPC=0x42 -> Fault=1, FaultPC=0x42, Pc held, IfId_Valid=0 indefinitely; repeat with BrPC=0x200 -> same; reset -> all REQ-026 values.
REQ-034 SHALL cover wrap: Pc=0x1FC, normal advance -> Pc=0x000, IfId_PC=0x1FC, FetchCnt incremented.
